// File: rtl/serial_frame_pkg.sv
// Shared state encoding and line levels for the serial frame transmitter.
// Pure declarations: no latency, no flow control.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic state_ready(input state_t s);
    return (s == IDLE) || (s == STOP);
  endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// WIDTH-bit load/shift-right register with bit counter; o_last marks the final data bit.
// Load wins over shift/increment in the same cycle; no backpressure of its own.
module serial_tx_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_shift,
  input  logic             i_inc,
  output logic             o_lsb,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else begin
      if (i_shift) r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      if (i_inc)   r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_lsb  = r_shift[0];
  assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, WIDTH data bits LSB first, optional even parity (SERIAL_TX_PARITY_EN), stop.
// Outputs registered and aligned with state; load accepted only in IDLE/STOP, otherwise dropped.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             outp,
  output logic             busy,
  output logic             done
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_outp, r_ready, r_busy, r_done;
  logic   w_outp_nxt, w_accept, w_shift, w_inc, w_lsb, w_last;

  assign w_accept = load && r_ready;

`ifdef SERIAL_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         r_par <= 1'b0;
    else if (w_accept) r_par <= ^data_in;
  end
`endif

  serial_tx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_accept),
    .i_data (data_in),
    .i_shift(w_shift),
    .i_inc  (w_inc),
    .o_lsb  (w_lsb),
    .o_last (w_last)
  );

  // outputs are computed from the next state so the line changes together with the state register
  always_comb begin
    w_state_nxt = IDLE;
    w_shift     = 1'b0;
    w_inc       = 1'b0;
    w_outp_nxt  = LINE_IDLE;
    case (r_state)
      IDLE:  w_state_nxt = w_accept ? START : IDLE;
      START: begin
        w_state_nxt = DATA;
        w_shift     = 1'b1;
      end
      DATA: begin
        if (w_last) begin
`ifdef SERIAL_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end else begin
          w_state_nxt = DATA;
          w_shift     = 1'b1;
          w_inc       = 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: w_state_nxt = STOP;
`endif
      STOP:    w_state_nxt = w_accept ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      START: w_outp_nxt = START_BIT;
      DATA:  w_outp_nxt = w_lsb;
`ifdef SERIAL_TX_PARITY_EN
      PARITY: w_outp_nxt = r_par;
`endif
      STOP:    w_outp_nxt = STOP_BIT;
      default: w_outp_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_outp  <= LINE_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_outp  <= w_outp_nxt;
      r_ready <= state_ready(w_state_nxt);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == STOP);
    end
  end

  assign ready = r_ready;
  assign outp  = r_outp;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
